// File: rtl/axis_pkg.sv
// Shared helpers for the AXI-Stream width downsizer: constant clog2 and
// TKEEP-to-lane-count decoding for trimmed final beats.
package axis_pkg;

    localparam int MAX_RATIO = 64;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Highest set lane decides the count; an all-zero mask still emits lane 0.
    function automatic int keep_nlanes(input logic [MAX_RATIO-1:0] keep);
        int n;
        n = 1;
        for (int k = 0; k < MAX_RATIO; k++) begin
            if (keep[k]) n = k + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/axis_downsizer_if.sv
// Generic AXI-Stream bundle used for both the wide input and narrow output sides.
interface axis_downsizer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 1,
    parameter int USER_WIDTH = 32
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/axis_downsizer.sv
// AXI-Stream width downsizer: each RATIO*M_WIDTH input beat leaves as up to RATIO
// M_WIDTH beats, lane 0 first, with final-beat trim from TKEEP and per-beat TUSER.
module axis_downsizer
    import axis_pkg::*;
#(
    parameter int M_WIDTH    = 32,
    parameter int RATIO      = 2,
    parameter int USER_WIDTH = 32
) (
    input  logic                  AXIS_ACLK,
    input  logic                  AXIS_ARESET,
    axis_downsizer_if.slave       s_axis,
    axis_downsizer_if.master      m_axis,
    output logic [USER_WIDTH-1:0] SRCDEST
);

    localparam int S_WIDTH = RATIO * M_WIDTH;
    localparam int IDX_W   = clog2(RATIO);

    logic [S_WIDTH-1:0]    data_reg;
    logic [IDX_W-1:0]      last_lane_reg;
    logic [IDX_W-1:0]      last_lane_next;
    logic [IDX_W-1:0]      idx_reg;
    logic                  last_reg;
    logic                  full_reg;
    logic                  sop_reg;
    logic [USER_WIDTH-1:0] user_reg;
    logic [USER_WIDTH-1:0] srcdest_reg;
    logic [MAX_RATIO-1:0]  keep_ext;
    logic                  at_last_lane;
    logic                  accept;
    logic [M_WIDTH-1:0]    lanes [RATIO];

    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
        assign lanes[gi] = data_reg[gi*M_WIDTH +: M_WIDTH];
    end

    // TKEEP only trims the closing beat of a packet; body beats always carry every lane.
    always_comb begin
        keep_ext              = '0;
        keep_ext[RATIO-1:0]   = s_axis.tkeep;
        last_lane_next        = IDX_W'(RATIO - 1);
        if (s_axis.tlast) begin
            last_lane_next = IDX_W'(keep_nlanes(keep_ext) - 1);
        end
    end

    assign at_last_lane = (idx_reg == last_lane_reg);

    // Refill in the same cycle the final lane leaves, so beats stream without bubbles.
    assign s_axis.tready = !full_reg | (m_axis.tready & at_last_lane);
    assign accept        = s_axis.tvalid & s_axis.tready;

    assign m_axis.tvalid = full_reg;
    assign m_axis.tdata  = lanes[idx_reg];
    assign m_axis.tlast  = full_reg & last_reg & at_last_lane;
    assign m_axis.tuser  = user_reg;
    assign m_axis.tkeep  = '1;
    assign SRCDEST       = srcdest_reg;

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            data_reg      <= '0;
            last_lane_reg <= '0;
            idx_reg       <= '0;
            last_reg      <= 1'b0;
            full_reg      <= 1'b0;
            sop_reg       <= 1'b1;
            user_reg      <= '0;
            srcdest_reg   <= '0;
        end else if (accept) begin
            data_reg      <= s_axis.tdata;
            last_lane_reg <= last_lane_next;
            last_reg      <= s_axis.tlast;
            user_reg      <= s_axis.tuser;
            full_reg      <= 1'b1;
            idx_reg       <= '0;
            sop_reg       <= s_axis.tlast;
            if (sop_reg) begin
                srcdest_reg <= s_axis.tuser;
            end
        end else if (full_reg && m_axis.tready) begin
            if (at_last_lane) begin
                full_reg <= 1'b0;
                idx_reg  <= '0;
            end else begin
                idx_reg  <= idx_reg + 1'b1;
            end
        end
    end

endmodule
